// File: rtl/say_issue_tracker.sv
// rtl/say_issue_tracker.sv - request queue, say issuer and in-order heard checker.
// Issue and enqueue handshakes are decoded from registered counts only.
module say_issue_tracker #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         enq_put_ena,
  input  logic [31:0]                  enq_put_v,
  output logic                         enq_put_rdy,
  output logic                         say_say_ena,
  output logic [31:0]                  say_say_v,
  input  logic                         say_say_rdy,
  input  logic                         heard_heard_ena,
  input  logic [31:0]                  heard_heard_v,
  output logic                         heard_heard_rdy,
  input  logic                         clr__ENA,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic [15:0]                  heard_count,
  output logic                         err_mismatch,
  output logic                         err_unexpected
);
  localparam int QW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int FW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [31:0]   r_q [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [QW-1:0] r_qcount;

  logic [31:0]   r_f [MAX_OUT];
  logic [FW-1:0] r_fhead;
  logic [FW-1:0] r_ftail;
  logic [OW-1:0] r_outstanding;

  logic [15:0]   r_heard_count;
  logic          r_err_mismatch;
  logic          r_err_unexpected;

  logic          w_put_rdy;
  logic          w_say_ena;
  logic          w_put;
  logic          w_say;
  logic          w_pop;
  logic          w_unexp;
  logic          w_miss;
  logic [FW-1:0] w_fhead_nxt;
  logic [FW-1:0] w_ftail_nxt;

  // Full queue refuses even when a pop happens this cycle: no bypass path.
  assign w_put_rdy = !RST && (r_qcount != QW'(DEPTH));
  assign w_say_ena = !RST && (r_qcount != '0) && (r_outstanding != OW'(MAX_OUT));
  assign w_put     = enq_put_ena && w_put_rdy;
  assign w_say     = w_say_ena && say_say_rdy;
  assign w_pop     = heard_heard_ena && (r_outstanding != '0);
  assign w_unexp   = heard_heard_ena && (r_outstanding == '0);
  assign w_miss    = w_pop && (r_f[r_fhead] != heard_heard_v);

  assign w_fhead_nxt = (MAX_OUT == 1) ? '0 : r_fhead + FW'(1);
  assign w_ftail_nxt = (MAX_OUT == 1) ? '0 : r_ftail + FW'(1);

  always_ff @(posedge CLK) begin
    if (w_put) r_q[r_tail] <= enq_put_v;
    if (w_say) r_f[r_ftail] <= r_q[r_head];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_qcount      <= '0;
      r_fhead       <= '0;
      r_ftail       <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_put) r_tail <= r_tail + PW'(1);
      if (w_say) r_head <= r_head + PW'(1);
      r_qcount <= r_qcount + QW'(w_put) - QW'(w_say);
      if (w_say) r_ftail <= w_ftail_nxt;
      if (w_pop) r_fhead <= w_fhead_nxt;
      r_outstanding <= r_outstanding + OW'(w_say) - OW'(w_pop);
    end
  end

  // Clear drops the count/flag update of a same-cycle heard; the pop above still happens.
  always_ff @(posedge CLK) begin
    if (RST || clr__ENA) begin
      r_heard_count    <= '0;
      r_err_mismatch   <= 1'b0;
      r_err_unexpected <= 1'b0;
    end else if (heard_heard_ena) begin
      r_heard_count <= r_heard_count + 16'd1;
      if (w_miss)  r_err_mismatch   <= 1'b1;
      if (w_unexp) r_err_unexpected <= 1'b1;
    end
  end

  assign enq_put_rdy     = w_put_rdy;
  assign say_say_ena     = w_say_ena;
  assign say_say_v       = r_q[r_head];
  assign heard_heard_rdy = 1'b1;
  assign outstanding     = r_outstanding;
  assign heard_count     = r_heard_count;
  assign err_mismatch    = r_err_mismatch;
  assign err_unexpected  = r_err_unexpected;
endmodule

// File: tb/tb_say_issue_tracker.sv
// tb/tb_say_issue_tracker.sv - directed self-checking bench for say_issue_tracker.
module tb_say_issue_tracker;
  logic        clk = 1'b0;
  logic        rst;
  logic        put_ena;
  logic [31:0] put_v;
  logic        put_rdy;
  logic        say_ena;
  logic [31:0] say_v;
  logic        say_rdy;
  logic        heard_ena;
  logic [31:0] heard_v;
  logic        heard_rdy;
  logic        clr;
  logic [1:0]  outstanding;
  logic [15:0] heard_count;
  logic        err_mismatch;
  logic        err_unexpected;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  say_issue_tracker #(.DEPTH(4), .MAX_OUT(2)) dut (
    .CLK             (clk),
    .RST             (rst),
    .enq_put_ena     (put_ena),
    .enq_put_v       (put_v),
    .enq_put_rdy     (put_rdy),
    .say_say_ena     (say_ena),
    .say_say_v       (say_v),
    .say_say_rdy     (say_rdy),
    .heard_heard_ena (heard_ena),
    .heard_heard_v   (heard_v),
    .heard_heard_rdy (heard_rdy),
    .clr__ENA        (clr),
    .outstanding     (outstanding),
    .heard_count     (heard_count),
    .err_mismatch    (err_mismatch),
    .err_unexpected  (err_unexpected)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input logic [1:0] o, input logic [15:0] hc,
                            input logic mm, input logic un);
    chk({tag, "_out"}, outstanding, o);
    chk({tag, "_hc"}, heard_count, hc);
    chk({tag, "_mm"}, err_mismatch, mm);
    chk({tag, "_un"}, err_unexpected, un);
  endtask

  initial begin
    rst = 1'b1; put_ena = 1'b0; put_v = '0; say_rdy = 1'b0;
    heard_ena = 1'b0; heard_v = '0; clr = 1'b0;
    #1;
    chk("rst_put_rdy", put_rdy, 1'b0);
    chk("rst_say_ena", say_ena, 1'b0);
    chk("heard_rdy", heard_rdy, 1'b1);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_status("reset", 2'd0, 16'd0, 1'b0, 1'b0);
    chk("reset_put_rdy", put_rdy, 1'b1);
    chk("reset_say_ena", say_ena, 1'b0);

    // single request echoed back
    say_rdy = 1'b1; put_ena = 1'b1; put_v = 32'h11;
    chk("t1_no_comb_path", say_ena, 1'b0);
    tick();
    put_ena = 1'b0;
    chk("t1_say_ena", say_ena, 1'b1);
    chk("t1_say_v", say_v, 32'h11);
    tick();
    chk("t1_say_ena_off", say_ena, 1'b0);
    chk("t1_out1", outstanding, 2'd1);
    heard_ena = 1'b1; heard_v = 32'h11;
    tick();
    heard_ena = 1'b0;
    chk_status("t1_done", 2'd0, 16'd1, 1'b0, 1'b0);

    // fill queue with downstream stalled, then drain in order
    say_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put_ena = 1'b1; put_v = 32'h21 + i;
      chk("t2_put_rdy", put_rdy, (i < 4) ? 1'b1 : 1'b0);
      tick();
    end
    put_ena = 1'b0;
    chk("t2_full_say_ena", say_ena, 1'b1);
    chk("t2_head", say_v, 32'h21);
    say_rdy = 1'b1;
    tick();
    chk("t2_a_out", outstanding, 2'd1);
    chk("t2_a_v", say_v, 32'h22);
    tick();
    chk("t2_b_out", outstanding, 2'd2);
    chk("t2_b_ena", say_ena, 1'b0);
    chk("t2_b_v", say_v, 32'h23);
    chk("t2_b_put_rdy", put_rdy, 1'b1);
    tick();
    chk("t2_c_out", outstanding, 2'd2);
    heard_ena = 1'b1; heard_v = 32'h21;
    chk("t2_max_ena_low", say_ena, 1'b0);
    tick();
    chk("t2_d_out", outstanding, 2'd1);
    chk("t2_d_ena", say_ena, 1'b1);
    chk("t2_d_v", say_v, 32'h23);
    heard_v = 32'h22;
    tick();
    chk("t2_e_out", outstanding, 2'd1);
    chk("t2_e_v", say_v, 32'h24);
    heard_v = 32'h23;
    tick();
    chk("t2_f_out", outstanding, 2'd1);
    chk("t2_f_ena", say_ena, 1'b0);
    heard_v = 32'h24;
    tick();
    heard_ena = 1'b0;
    chk_status("t2_done", 2'd0, 16'd5, 1'b0, 1'b0);

    // mismatch on second response, then clear
    put_ena = 1'b1; put_v = 32'hA;
    tick();
    put_v = 32'hB;
    tick();
    put_ena = 1'b0;
    tick();
    chk("t3_out2", outstanding, 2'd2);
    heard_ena = 1'b1; heard_v = 32'hA;
    tick();
    chk_status("t3_first", 2'd1, 16'd6, 1'b0, 1'b0);
    heard_v = 32'hC;
    tick();
    heard_ena = 1'b0;
    chk_status("t3_second", 2'd0, 16'd7, 1'b1, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_status("t3_clr", 2'd0, 16'd0, 1'b0, 1'b0);

    // heard in the same cycle as the first issue is unexpected
    put_ena = 1'b1; put_v = 32'h44;
    tick();
    put_ena = 1'b0;
    chk("t4_ena", say_ena, 1'b1);
    heard_ena = 1'b1; heard_v = 32'h44;
    tick();
    chk_status("t4_unexp", 2'd1, 16'd1, 1'b0, 1'b1);
    tick();
    chk_status("t4_drain", 2'd0, 16'd2, 1'b0, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0; heard_ena = 1'b0;
    chk_status("t4_clr_wins", 2'd0, 16'd0, 1'b0, 1'b0);

    // reset with 3 queued and 2 in flight
    put_ena = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put_v = 32'h51 + i;
      tick();
    end
    put_ena = 1'b0;
    chk("t5_out2", outstanding, 2'd2);
    chk("t5_head", say_v, 32'h53);
    heard_ena = 1'b1; heard_v = 32'h99;
    tick();
    heard_ena = 1'b0;
    chk("t5_mm_before", err_mismatch, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_put_rdy", put_rdy, 1'b0);
    chk("t5_rst_say_ena", say_ena, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk_status("t5_after", 2'd0, 16'd0, 1'b0, 1'b0);
    chk("t5_after_ena", say_ena, 1'b0);
    put_ena = 1'b1; put_v = 32'h66;
    tick();
    put_ena = 1'b0;
    chk("t5_new_ena", say_ena, 1'b1);
    chk("t5_new_v", say_v, 32'h66);
    tick();
    heard_ena = 1'b1; heard_v = 32'h66;
    tick();
    heard_ena = 1'b0;
    chk_status("t5_new_done", 2'd0, 16'd1, 1'b0, 1'b0);

    // 65536 matching responses wrap heard_count
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 65538; k++) begin
      put_ena = (k < 65536);
      put_v = k;
      heard_ena = (k >= 2);
      heard_v = k - 2;
      tick();
      if (k == 65536) chk("t6_ffff", heard_count, 16'hFFFF);
    end
    put_ena = 1'b0; heard_ena = 1'b0;
    chk_status("t6_wrap", 2'd0, 16'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
